wmst_out_fm_ctrl: RTL and testbench

Write-master controller that stores a computed output-feature-map tile from the on-chip output FIFO back to external memory. It walks the tile row by row (Tm channels x Tr rows) and issues one Tc-word burst per row to the Avalon write master. Each burst carries a byte address and a word length. It is the write-side counterpart of the out-FM read-master controller and shares the same tile-base inputs and the same start/done handshake style.

---
 rtl/out_fm_ctrl_pkg.sv | 34 +++
 rtl/nest2_counter.sv | 47 ++++
 rtl/wmst_out_fm_ctrl.sv | 154 +++++++++++++++
 tb/tb_wmst_out_fm_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/out_fm_ctrl_pkg.sv
// out_fm_ctrl_pkg
// Definitions shared by the out-FM read-side and write-side controllers:
//   - fm_state_t   : controller state encoding. Both controllers use the same
//                    values so debug traces read the same way.
//   - fm_byte_addr : turns (base, channel, row, col) into a byte address for a
//                    row-major [channel][row][col] feature map of 32-bit words.
package out_fm_ctrl_pkg;

    localparam int FM_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        CONFIG = 3'b001,
        WAIT   = 3'b010,
        TRANS  = 3'b011,
        DONE   = 3'b111
    } fm_state_t;

    // The word address wraps modulo 2^FM_ADDR_W. The shift by 2 turns the
    // word address into a byte address for 4-byte words.
    function automatic logic [FM_ADDR_W-1:0] fm_byte_addr(
        input logic [FM_ADDR_W-1:0] base,
        input logic [FM_ADDR_W-1:0] n,
        input logic [FM_ADDR_W-1:0] row,
        input logic [FM_ADDR_W-1:0] col,
        input logic [FM_ADDR_W-1:0] r_dim,
        input logic [FM_ADDR_W-1:0] c_dim
    );
        logic [FM_ADDR_W-1:0] word;
        word = base + n * r_dim * c_dim + row * c_dim + col;
        return word << 2;
    endfunction

endpackage

// File: rtl/nest2_counter.sv
// nest2_counter
// Two nested up-counters. n0 is the inner counter and runs 0..N0_MAX-1. When
// n0 wraps, the outer counter n1 advances and runs 0..N1_MAX-1.
//   clk, rst (async, active-low)
//   en    : advance by one position
//   clr   : synchronous clear; takes priority over en
//   n1/n0 : outer/inner count
//   last  : high while at position (N1_MAX-1, N0_MAX-1)
module nest2_counter #(
    parameter int W      = 16,
    parameter int N1_MAX = 16,
    parameter int N0_MAX = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] n1,
    output logic [W-1:0] n0,
    output logic         last
);

    logic n0_wrap;
    logic n1_wrap;

    assign n0_wrap = (n0 == W'(N0_MAX - 1));
    assign n1_wrap = (n1 == W'(N1_MAX - 1));
    assign last    = n0_wrap & n1_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n1 <= '0;
            n0 <= '0;
        end else if (clr) begin
            n1 <= '0;
            n0 <= '0;
        end else if (en) begin
            if (n0_wrap) begin
                n0 <= '0;
                n1 <= n1_wrap ? '0 : n1 + W'(1);
            end else begin
                n0 <= n0 + W'(1);
            end
        end
    end

endmodule

// File: rtl/wmst_out_fm_ctrl.sv
// wmst_out_fm_ctrl
// Write-master controller that stores one output-feature-map tile from the
// output FIFO to external memory. For each channel tm (outer loop) and each
// row tr (inner loop) of the tile, it issues one burst of up to Tc words.
//   clk, rst           : clock, asynchronous active-low reset
//   store_start        : level request; sampled only in IDLE
//   store_done         : one-cycle pulse after the tile's last burst
//   param_waddr/iolen  : registered burst byte address / word length
//   store_trans_start  : one-cycle burst launch pulse
//   store_trans_done   : burst completion pulse from the write master
//   store_fifo_cnt     : words currently held in the output FIFO
//   tile_base_m/row/col: tile origin in the output feature map
// Optional build macro WMST_STALL_CNT_EN adds the output stall_cycles. It
// counts the cycles spent in WAIT while the FIFO does not hold a full row.
module wmst_out_fm_ctrl
    import out_fm_ctrl_pkg::*;
#(
    parameter int AW          = 12,
    parameter int CW          = 16,
    parameter int DW          = 32,
    parameter int M           = 32,
    parameter int R           = 64,
    parameter int C           = 32,
    parameter int Tm          = 16,
    parameter int Tr          = 64,
    parameter int Tc          = 16,
    parameter int OUT_FM_BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          store_start,
    output logic          store_done,
    output logic [DW-1:0] param_waddr,
    output logic [AW-1:0] param_iolen,
    output logic          store_trans_start,
    input  logic          store_trans_done,
    input  logic [AW-1:0] store_fifo_cnt,
    input  logic [CW-1:0] tile_base_m,
    input  logic [CW-1:0] tile_base_row,
    input  logic [CW-1:0] tile_base_col
`ifdef WMST_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    fm_state_t     state;
    logic [CW-1:0] tm;
    logic [CW-1:0] tr;
    logic          last_pos;
    logic          skip;
    logic          ready;
    logic          cnt_en;
    logic [CW-1:0] col_left;
    logic [CW-1:0] len_w;
    logic [AW-1:0] len;
    logic [DW-1:0] waddr_calc;

    // The last tile in a row may be narrower than Tc.
    assign col_left = CW'(C) - tile_base_col;
    assign len_w    = (col_left < CW'(Tc)) ? col_left : CW'(Tc);
    assign len      = AW'(len_w);
    assign ready    = (store_fifo_cnt >= len);

    // Positions that fall past the feature-map edge do not issue a burst.
    assign skip = ((32'(tile_base_row) + 32'(tr)) >= 32'(R)) ||
                  ((32'(tile_base_m)   + 32'(tm)) >= 32'(M));

    assign waddr_calc = DW'(fm_byte_addr(32'(OUT_FM_BASE),
                                         32'(tile_base_m) + 32'(tm),
                                         32'(tile_base_row) + 32'(tr),
                                         32'(tile_base_col),
                                         32'(R), 32'(C)));

    // The counter holds at the last position. The IDLE-side store_done pulse
    // then clears it for the next tile.
    assign cnt_en = ~last_pos & (((state == WAIT) & skip) | (state == DONE));

    nest2_counter #(
        .W      (CW),
        .N1_MAX (Tm),
        .N0_MAX (Tr)
    ) u_pos_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (store_done),
        .n1   (tm),
        .n0   (tr),
        .last (last_pos)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            store_done        <= 1'b0;
            store_trans_start <= 1'b0;
            param_waddr       <= '0;
            param_iolen       <= '0;
        end else begin
            store_done        <= 1'b0;
            store_trans_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_start)
                        state <= WAIT;
                end
                WAIT: begin
                    if (skip) begin
                        if (last_pos)
                            state <= DONE;
                    end else if (ready) begin
                        state <= CONFIG;
                    end
                end
                CONFIG: begin
                    param_waddr       <= waddr_calc;
                    param_iolen       <= len;
                    store_trans_start <= 1'b1;
                    state             <= TRANS;
                end
                TRANS: begin
                    if (store_trans_done)
                        state <= DONE;
                end
                DONE: begin
                    if (last_pos) begin
                        store_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WMST_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if ((state == IDLE) && store_start)
            stall_cycles <= '0;
        else if ((state == WAIT) && !skip && !ready)
            stall_cycles <= sat_inc32(stall_cycles);
    end
`endif

endmodule

// File: tb/tb_wmst_out_fm_ctrl.sv
module tb_wmst_out_fm_ctrl;

    localparam int AW_P = 12;
    localparam int CW_P = 16;
    localparam int DW_P = 32;
    localparam int M_P  = 4;
    localparam int R_P  = 4;
    localparam int C_P  = 8;
    localparam int TM_P = 2;
    localparam int TR_P = 2;
    localparam int TC_P = 4;
    localparam int BUDGET = 2000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            store_start = 1'b0;
    logic            store_done;
    logic [DW_P-1:0] param_waddr;
    logic [AW_P-1:0] param_iolen;
    logic            store_trans_start;
    logic            store_trans_done = 1'b0;
    logic [AW_P-1:0] store_fifo_cnt = '0;
    logic [CW_P-1:0] tile_base_m = '0;
    logic [CW_P-1:0] tile_base_row = '0;
    logic [CW_P-1:0] tile_base_col = '0;
`ifdef WMST_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    wmst_out_fm_ctrl #(
        .AW(AW_P), .CW(CW_P), .DW(DW_P), .M(M_P), .R(R_P), .C(C_P),
        .Tm(TM_P), .Tr(TR_P), .Tc(TC_P), .OUT_FM_BASE(0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .store_start       (store_start),
        .store_done        (store_done),
        .param_waddr       (param_waddr),
        .param_iolen       (param_iolen),
        .store_trans_start (store_trans_start),
        .store_trans_done  (store_trans_done),
        .store_fifo_cnt    (store_fifo_cnt),
        .tile_base_m       (tile_base_m),
        .tile_base_row     (tile_base_row),
        .tile_base_col     (tile_base_col)
`ifdef WMST_STALL_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_waddr"}, param_waddr, 32'd0);
        check_val({tag, "_iolen"}, 32'(param_iolen), 32'd0);
        check_val({tag, "_tstart"}, 32'(store_trans_start), 32'd0);
        check_val({tag, "_done"}, 32'(store_done), 32'd0);
    endtask

    // Plays the write master for one tile. The expected bursts come from
    // walking the tile coordinates directly.
    //   fmode: 0 = FIFO held at fval, 1 = random 0..fval each cycle,
    //          2 = FIFO at 3 for the first 10 cycles, then 4.
    //   rst_at: assert reset while the n-th burst is in flight (0 = never).
    task automatic run_tile(input int bm, input int br, input int bc,
                            input int fmode, input int fval,
                            input bit pulse, input bit hold, input bit spur,
                            input int rst_at, output int first_ts);
        int  exp_addr[$];
        int  exp_len[$];
        int  len, n_exp, nts, dly, cnt_prev, ok;
        bit  outst, done_seen, aborted;

        len = ((C_P - bc) < TC_P) ? (C_P - bc) : TC_P;
        for (int m = 0; m < TM_P; m++)
            for (int r = 0; r < TR_P; r++)
                if ((bm + m) < M_P && (br + r) < R_P) begin
                    exp_addr.push_back(((bm + m) * R_P * C_P + (br + r) * C_P + bc) * 4);
                    exp_len.push_back(len);
                end
        n_exp = exp_addr.size();

        first_ts = -1; nts = 0; outst = 0; dly = 0; done_seen = 0; aborted = 0;
        tile_base_m   = 16'(bm);
        tile_base_row = 16'(br);
        tile_base_col = 16'(bc);
        store_fifo_cnt = (fmode == 2) ? 12'd3 : 12'(fval);
        cnt_prev = 0;
        if (pulse) store_start = 1'b1;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(posedge clk); #1;
            if (store_trans_start) begin
                if (first_ts < 0) first_ts = cyc;
                nts++;
                if (exp_addr.size() > 0) begin
                    check_val("waddr", param_waddr, 32'(exp_addr.pop_front()));
                    check_val("iolen", 32'(param_iolen), 32'(exp_len.pop_front()));
                end else begin
                    check_val("burst_overrun", 32'(nts), 32'(n_exp));
                end
                ok = (cnt_prev >= len) ? 1 : 0;
                check_val("fifo_ready_at_launch", 32'(ok), 32'd1);
                if (rst_at == nts) begin
                    #2 rst = 1'b0;
                    #1 check_idle_outputs("async_rst");
                    store_trans_done = 1'b0;
                    store_start = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b1;
                    aborted = 1;
                    break;
                end
                outst = 1;
                dly = $urandom_range(1, 4);
            end
            if (store_done) begin
                check_val("bursts_per_tile", 32'(nts), 32'(n_exp));
                done_seen = 1;
            end
            cnt_prev = int'(store_fifo_cnt);
            case (fmode)
                0:       store_fifo_cnt = 12'(fval);
                1:       store_fifo_cnt = 12'($urandom_range(0, fval));
                default: store_fifo_cnt = (cyc < 10) ? 12'd3 : 12'd4;
            endcase
            if (outst) begin
                dly--;
                store_trans_done = (dly == 0);
                if (dly == 0) outst = 0;
            end else begin
                store_trans_done = spur && ($urandom_range(0, 2) == 0);
            end
            if (!hold) store_start = 1'b0;
            if (done_seen) begin
                store_trans_done = 1'b0;
                break;
            end
        end
        if (!aborted && !done_seen)
            check_val("done_timeout", 32'(done_seen), 32'd1);
    endtask

    initial begin
        int fts;
        int bm, br, bc;

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Full tile, FIFO always ready: 0x00, 0x20, 0x80, 0xA0
        run_tile(0, 0, 0, 0, 16, 1, 0, 0, 0, fts);
        check_val("base_first_latency", 32'(fts), 32'd2);

        // FIFO starvation: launch only two cycles after count reaches 4
        run_tile(0, 0, 0, 2, 0, 1, 0, 0, 0, fts);
        check_val("starve_first_latency", 32'(fts), 32'd12);
`ifdef WMST_STALL_CNT_EN
        check_val("stall_cycles", stall_cycles, 32'd10);
`endif

        // Column clip: 2-word rows, FIFO holding exactly 2 words
        run_tile(0, 0, 6, 0, 2, 1, 0, 0, 0, fts);
        check_val("colclip_first_latency", 32'(fts), 32'd2);

        // Row/channel clip: only (m=3,row=3) survives
        run_tile(3, 3, 0, 0, 16, 1, 0, 0, 0, fts);

        // Reset while the second burst is in flight, then restart from 0x00
        run_tile(0, 0, 0, 0, 16, 1, 0, 0, 2, fts);
        check_idle_outputs("post_rst");
        run_tile(0, 0, 0, 0, 16, 1, 0, 0, 0, fts);
        check_val("restart_first_latency", 32'(fts), 32'd2);

        // Spurious trans_done pulses, and store_start held across store_done
        run_tile(0, 0, 0, 0, 16, 1, 1, 1, 0, fts);
        run_tile(0, 0, 0, 0, 16, 0, 0, 1, 0, fts);
        check_val("back_to_back_start", 32'(fts), 32'd2);

        // Random tile origins and FIFO levels
        for (int k = 0; k < 10; k++) begin
            bm = $urandom_range(0, M_P - 1);
            br = $urandom_range(0, R_P - 1);
            bc = $urandom_range(0, C_P - 1);
            run_tile(bm, br, bc, 1, 6, 1, 0, 1, 0, fts);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
